// File: rtl/pll_tpm_pkg.sv
// Shared state encoding and parameter defaults for the PLL test-port master.
// State values are plain localparams so legacy code can compare them as bit vectors.
package pll_tpm_pkg;

  localparam int SHIFT_LEN_DEF    = 26;
  localparam int SCLK_DIV_DEF     = 4;
  localparam int LOCK_TIMEOUT_DEF = 1024;

  typedef logic [2:0] tpm_state_t;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_SHIFT_LO  = 3'd1;
  localparam logic [2:0] ST_SHIFT_HI  = 3'd2;
  localparam logic [2:0] ST_LOCK_WAIT = 3'd3;
  localparam logic [2:0] ST_FINISH    = 3'd4;

  function automatic logic tpm_shifting(input tpm_state_t st);
    return (st == ST_SHIFT_LO) || (st == ST_SHIFT_HI);
  endfunction

endpackage

// File: rtl/pll_tpm_clkdiv.sv
// SCLK half-period timer: tick marks the last cycle of a half period, first the
// opening cycle. Held at zero whenever en is low so every phase starts aligned.
module pll_tpm_clkdiv #(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tick,
  output logic first
);
  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt;

  assign tick  = en && (cnt == CW'(DIV - 1));
  assign first = en && (cnt == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)              cnt <= '0;
    else if (!en || tick) cnt <= '0;
    else                  cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/pll_test_port_master.sv
// PLL test-port serial master: shifts WDATA out MSB-first on SDI/SCLK and captures SDO.
// Define PLL_TPM_LOCK_WAIT_EN to wait for LOCK (bounded by LOCK_TIMEOUT) before DONE.
import pll_tpm_pkg::*;

module pll_test_port_master #(
  parameter int SHIFT_LEN    = SHIFT_LEN_DEF,
  parameter int SCLK_DIV     = SCLK_DIV_DEF,
  parameter int LOCK_TIMEOUT = LOCK_TIMEOUT_DEF
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 START,
  input  logic [SHIFT_LEN-1:0] WDATA,
  output logic                 BUSY,
  output logic                 DONE,
  output logic [SHIFT_LEN-1:0] RDATA,
  output logic                 TIMEOUT,
  output logic                 SCLK,
  output logic                 SDI,
  input  logic                 SDO,
  input  logic                 LOCK,
  input  logic [7:0]           DELAY_IN,
  input  logic                 DELAY_WE,
  output logic [7:0]           DYNAMICDELAY
);
  localparam int BW = $clog2(SHIFT_LEN);

`ifdef PLL_TPM_LOCK_WAIT_EN
  localparam logic [2:0] ST_AFTER_SHIFT = ST_LOCK_WAIT;
`else
  localparam logic [2:0] ST_AFTER_SHIFT = ST_FINISH;
`endif

  tpm_state_t           state, state_nxt;
  logic [SHIFT_LEN-1:0] tx, rx, rx_nxt;
  logic [BW-1:0]        bitcnt;
  logic                 shifting, tick, first, last_bit, lock_exit;

  assign shifting = tpm_shifting(state);
  assign last_bit = (bitcnt == BW'(SHIFT_LEN - 1));

  pll_tpm_clkdiv #(.DIV(SCLK_DIV)) u_clkdiv (
    .clk   (CLK),
    .rst   (RST),
    .en    (shifting),
    .tick  (tick),
    .first (first)
  );

  // SDO is sampled once, in the opening cycle of the high phase.
  assign rx_nxt = (state == ST_SHIFT_HI && first) ? {rx[SHIFT_LEN-2:0], SDO} : rx;

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:      if (START)     state_nxt = ST_SHIFT_LO;
      ST_SHIFT_LO:  if (tick)      state_nxt = ST_SHIFT_HI;
      ST_SHIFT_HI:  if (tick)      state_nxt = last_bit ? ST_AFTER_SHIFT : ST_SHIFT_LO;
      ST_LOCK_WAIT: if (lock_exit) state_nxt = ST_FINISH;
      ST_FINISH:                   state_nxt = ST_IDLE;
      default:                     state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state  <= ST_IDLE;
      tx     <= '0;
      rx     <= '0;
      bitcnt <= '0;
      RDATA  <= '0;
    end else begin
      state <= state_nxt;
      rx    <= rx_nxt;
      if (state == ST_IDLE && START) begin
        tx     <= WDATA;
        rx     <= '0;
        bitcnt <= '0;
      end else if (state == ST_SHIFT_HI && tick) begin
        tx     <= {tx[SHIFT_LEN-2:0], 1'b0};
        bitcnt <= bitcnt + 1'b1;
      end
      // Load on entry so RDATA is already valid in the DONE cycle.
      if (state_nxt == ST_FINISH) RDATA <= rx_nxt;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST)           DYNAMICDELAY <= 8'h00;
    else if (DELAY_WE) DYNAMICDELAY <= DELAY_IN;
  end

`ifdef PLL_TPM_LOCK_WAIT_EN
  logic [15:0] lcnt;
  logic        timeout_q;

  // LOCK wins over an expiring timer in the same cycle.
  assign lock_exit = LOCK || (lcnt == 16'(LOCK_TIMEOUT - 1));
  assign TIMEOUT   = timeout_q;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      lcnt      <= '0;
      timeout_q <= 1'b0;
    end else begin
      lcnt <= (state == ST_LOCK_WAIT) ? lcnt + 1'b1 : '0;
      if (state == ST_IDLE && START)
        timeout_q <= 1'b0;
      else if (state == ST_LOCK_WAIT && lock_exit)
        timeout_q <= !LOCK;
    end
  end
`else
  logic unused_lock;

  assign unused_lock = LOCK;
  assign lock_exit   = 1'b1;
  assign TIMEOUT     = 1'b0;
`endif

  assign BUSY = (state != ST_IDLE);
  assign DONE = (state == ST_FINISH);
  assign SCLK = (state == ST_SHIFT_HI);
  assign SDI  = shifting & tx[SHIFT_LEN-1];

endmodule

// File: doc/pll_test_port_master.md
PLL_TEST_PORT_MASTER -- requirements
Module: pll_test_port_master

Interface
REQ-001 The block SHALL have parameter SHIFT_LEN, default 26: number of bits per serial transfer; legal range 2..64.
REQ-002 The block SHALL have parameter SCLK_DIV, default 4: SCLK half-period in CLK cycles; legal range 1..255.
REQ-003 The block SHALL have parameter LOCK_TIMEOUT, default 1024: maximum number of CLK cycles spent waiting for LOCK; legal range 1..65535.
REQ-004 The block SHALL have port CLK, input, width 1: the single clock; all logic is rising-edge.
REQ-005 The block SHALL have port RST, input, width 1: asynchronous, active-high reset.
REQ-006 The block SHALL have port START, input, width 1: transfer request, sampled only in IDLE.
REQ-007 The block SHALL have port WDATA, input, width SHIFT_LEN: word to shift out, MSB first.
REQ-008 The block SHALL have port BUSY, output, width 1: high in every state other than IDLE.
REQ-009 The block SHALL have port DONE, output, width 1: one-cycle pulse marking transfer completion.
REQ-010 The block SHALL have port RDATA, output, width SHIFT_LEN: word captured from SDO.
REQ-011 The block SHALL have port TIMEOUT, output, width 1: LOCK was not seen within LOCK_TIMEOUT cycles; valid while DONE is high.
REQ-012 The block SHALL have ports SCLK, SDI (outputs, width 1) and SDO (input, width 1): PLL test-port serial pins.
REQ-013 The block SHALL have port LOCK, input, width 1: the PLL lock indicator.
REQ-014 The block SHALL have ports DELAY_IN (input, width 8) and DELAY_WE (input, width 1): write port for the delay register.
REQ-015 The block SHALL have port DYNAMICDELAY, output, width 8: registered delay value driven to the PLL.

Function
REQ-016 The block SHALL implement a state machine with states IDLE, SHIFT_LO, SHIFT_HI, LOCK_WAIT and FINISH.
REQ-017 In IDLE with START=1, the block SHALL load WDATA into the shift register and enter SHIFT_LO on the next cycle.
REQ-018 SDI SHALL present the current MSB of the shift register throughout each bit period.
REQ-019 In SHIFT_LO, SCLK SHALL be 0 for SCLK_DIV cycles, after which the block enters SHIFT_HI.
REQ-020 In SHIFT_HI, SCLK SHALL be 1 for SCLK_DIV cycles.
REQ-021 The block SHALL sample SDO in the first cycle of SHIFT_HI and shift the sampled bit into the capture register LSB.
REQ-022 At the end of each SHIFT_HI period, the block SHALL shift the transmit register left by one bit.
REQ-023 After the SHIFT_LEN-th SHIFT_HI period, the block SHALL enter FINISH directly, or enter LOCK_WAIT when REQ-034 applies.
REQ-024 SCLK SHALL be 0 in every state other than SHIFT_HI.
REQ-025 The FINISH state SHALL last exactly one cycle.
REQ-026 In the FINISH cycle, DONE SHALL be 1 and RDATA SHALL be updated from the capture register in the same cycle.
REQ-027 The block SHALL return from FINISH to IDLE.
REQ-028 Without LOCK_WAIT, DONE SHALL assert exactly 2*SCLK_DIV*SHIFT_LEN+1 cycles after the cycle in which START is accepted.
REQ-029 The block SHALL ignore START in every state other than IDLE.
REQ-030 START in the FINISH cycle SHALL be ignored; a new transfer is accepted no earlier than the following IDLE cycle.
REQ-031 RDATA SHALL hold its value between transfers.
REQ-032 When DELAY_WE=1, DYNAMICDELAY SHALL load DELAY_IN in any state, with one cycle of latency.

Reset
REQ-033 While RST is high, the block SHALL force: state=IDLE, SCLK=0, SDI=0, BUSY=0, DONE=0, TIMEOUT=0, RDATA=0, DYNAMICDELAY=8'h00, and all counters cleared; a reset asserted mid-transfer SHALL abort the transfer without asserting DONE.

Configuration
REQ-034 With macro PLL_TPM_LOCK_WAIT_EN defined, the block SHALL enter LOCK_WAIT after the last bit and leave for FINISH on the first cycle in which LOCK=1 (TIMEOUT=0), or after LOCK_TIMEOUT cycles without LOCK (TIMEOUT=1).
REQ-035 Without PLL_TPM_LOCK_WAIT_EN, LOCK_WAIT SHALL be unreachable, LOCK SHALL be ignored, and TIMEOUT SHALL be tied to 0.

Structure
REQ-036 A shared package pll_tpm_pkg SHALL hold the state enum and the default parameter constants.
REQ-037 A sub-module pll_tpm_clkdiv SHALL generate the SCLK_DIV half-period tick.

Verification
REQ-038 With SHIFT_LEN=8, SCLK_DIV=2, WDATA=8'hA5 and SDO looped to SDI, the bench SHALL check that DONE asserts 33 cycles after START and RDATA=8'hA5.
REQ-039 With SDO held at 1 and WDATA=8'h00, the bench SHALL check that SDI stays 0 for the whole transfer, RDATA=8'hFF, and exactly 8 SCLK rising edges occur.
REQ-040 With START pulsed again during SHIFT_HI, the bench SHALL check that the extra START is ignored and exactly one DONE pulse occurs.
REQ-041 With RST pulsed during the 4th bit, the bench SHALL check that SCLK=0, BUSY=0, no DONE occurs, and a following transfer completes normally.
REQ-042 With DELAY_WE=1 and DELAY_IN=8'h3C during a transfer, the bench SHALL check that DYNAMICDELAY=8'h3C on the next cycle.
REQ-043 With PLL_TPM_LOCK_WAIT_EN defined, the bench SHALL check that LOCK rising 10 cycles after the last bit gives DONE with TIMEOUT=0, and that LOCK held at 0 gives DONE after LOCK_TIMEOUT cycles with TIMEOUT=1.
